// File: rtl/irq_source_unit.sv
// Edge-detects device interrupt lines into a pending register and presents one
// locked request at a time to the core, retiring it on take/return pulses.
module irq_source_unit #(
  parameter int          NUM_SRC    = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h1000_0010,
  localparam int         IDW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] en_mask_i,
  input  logic               irq_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o,
  output logic [IDW-1:0]     irq_id_o,
  output logic               busy_o,
  output logic [NUM_SRC-1:0] pending_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [IDW-1:0]     id, id_next, low_idx;
  logic [NUM_SRC-1:0] src_q, pending, rise, clr, eligible;

  assign rise     = src_i & ~src_q;
  assign eligible = pending & en_mask_i;
  assign clr      = (state == REQ && irq_i) ? (NUM_SRC'(1) << id) : '0;

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) low_idx = IDW'(i);
    end
  end

  always_comb begin
    state_next = state;
    id_next    = id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          id_next    = low_idx;
        end
      end
      REQ:     if (irq_i)     state_next = SERVICE;
      SERVICE: if (irq_ret_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rise on the bit being cleared re-sets it in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      id      <= '0;
      src_q   <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      id      <= id_next;
      src_q   <= src_i;
      pending <= (pending & ~clr) | (rise & en_mask_i);
    end
  end

  assign irq_req_o   = (state == REQ);
  assign busy_o      = (state == SERVICE);
  assign irq_id_o    = (state == IDLE) ? '0 : id;
  assign irq_cause_o = (state == IDLE) ? 32'd0 : CAUSE_BASE + 32'(id);
  assign pending_o   = pending;

endmodule

// File: tb/tb_irq_source_unit.sv
// Self-checking bench for irq_source_unit: directed scenarios with fixed
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_irq_source_unit;

  localparam int          NUM_SRC    = 16;
  localparam logic [31:0] CAUSE_BASE = 32'h1000_0010;
  localparam int          IDW        = $clog2(NUM_SRC);
  localparam int          M_IDLE = 0, M_REQ = 1, M_SVC = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] src = '0;
  logic [NUM_SRC-1:0] mask = '1;
  logic               irq = 1'b0;
  logic               ret = 1'b0;
  logic               irq_req;
  logic [31:0]        irq_cause;
  logic [IDW-1:0]     irq_id;
  logic               busy;
  logic [NUM_SRC-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model: which phase the handshake is in, locked source, pending set
  int                 m_mode = M_IDLE;
  int                 m_id = 0;
  logic [NUM_SRC-1:0] m_pending = '0;
  logic [NUM_SRC-1:0] m_prev_src = '0;

  irq_source_unit #(.NUM_SRC(NUM_SRC), .CAUSE_BASE(CAUSE_BASE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_i       (src),
    .en_mask_i   (mask),
    .irq_i       (irq),
    .irq_ret_i   (ret),
    .irq_req_o   (irq_req),
    .irq_cause_o (irq_cause),
    .irq_id_o    (irq_id),
    .busy_o      (busy),
    .pending_o   (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NUM_SRC-1:0] s,
                               input logic [NUM_SRC-1:0] m, input logic t, input logic rt);
    rst_n = r;
    src   = s;
    mask  = m;
    irq   = t;
    ret   = rt;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic modelEdge();
    logic [NUM_SRC-1:0] rising, cleared, elig;
    int lowest;
    rising  = src & ~m_prev_src;
    cleared = '0;
    lowest  = -1;
    if (!rst_n) begin
      m_mode     = M_IDLE;
      m_id       = 0;
      m_pending  = '0;
      m_prev_src = '0;
    end else begin
      if (m_mode == M_IDLE) begin
        elig = m_pending & mask;
        for (int i = 0; i < NUM_SRC; i++)
          if (elig[i] && lowest < 0) lowest = i;
        if (lowest >= 0) begin
          m_mode = M_REQ;
          m_id   = lowest;
        end
      end else if (m_mode == M_REQ) begin
        if (irq) begin
          cleared[m_id] = 1'b1;
          m_mode = M_SVC;
        end
      end else if (ret) begin
        m_mode = M_IDLE;
      end
      m_pending  = (m_pending & ~cleared) | (rising & mask);
      m_prev_src = src;
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("req",     32'(irq_req),   32'(m_mode == M_REQ));
    checkOutput("busy",    32'(busy),      32'(m_mode == M_SVC));
    checkOutput("id",      32'(irq_id),    (m_mode == M_IDLE) ? 32'd0 : 32'(m_id));
    checkOutput("cause",   irq_cause,      (m_mode == M_IDLE) ? 32'd0 : CAUSE_BASE + 32'(m_id));
    checkOutput("pending", 32'(pending),   32'(m_pending));
  endtask

  initial begin
    logic [NUM_SRC-1:0] s;

    // Reset then a single rise on line 3
    applyStimulus(1'b0, '0, '1, 1'b0, 1'b0); step(); step();
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 16'h0008, '1, 1'b0, 1'b0); step();
    checkOutput("t1_pending", 32'(pending), 32'h0008);
    checkOutput("t1_req_early", 32'(irq_req), 32'd0);
    step();
    checkOutput("t1_req", 32'(irq_req), 32'd1);
    checkOutput("t1_id", 32'(irq_id), 32'd3);
    checkOutput("t1_cause", irq_cause, 32'h1000_0013);
    applyStimulus(1'b1, 16'h0008, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, 16'h0008, '1, 1'b0, 1'b1); step();
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b0); step();

    // Simultaneous rises on 7 and 2: lowest index first
    applyStimulus(1'b1, 16'h0084, '1, 1'b0, 1'b0); step(); step();
    checkOutput("t2_id_first", 32'(irq_id), 32'd2);
    applyStimulus(1'b1, 16'h0084, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, 16'h0084, '1, 1'b0, 1'b1); step();
    checkOutput("t2_idle_req", 32'(irq_req), 32'd0);
    applyStimulus(1'b1, 16'h0084, '1, 1'b0, 1'b0); step();
    checkOutput("t2_id_second", 32'(irq_id), 32'd7);
    checkOutput("t2_cause", irq_cause, 32'h1000_0017);
    applyStimulus(1'b1, 16'h0084, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b1); step();

    // Higher-priority arrival while locked on 5
    applyStimulus(1'b1, 16'h0020, '1, 1'b0, 1'b0); step(); step();
    applyStimulus(1'b1, 16'h0022, '1, 1'b0, 1'b0); step();
    checkOutput("t3_locked", 32'(irq_id), 32'd5);
    checkOutput("t3_pend1", 32'(pending[1]), 32'd1);
    applyStimulus(1'b1, 16'h0022, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, 16'h0022, '1, 1'b0, 1'b1); step();
    applyStimulus(1'b1, 16'h0022, '1, 1'b0, 1'b0); step();
    checkOutput("t3_next", 32'(irq_id), 32'd1);
    applyStimulus(1'b1, 16'h0022, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b1); step();

    // Masked rise is discarded for good
    applyStimulus(1'b1, 16'h0010, 16'hFFEF, 1'b0, 1'b0); step(); step();
    checkOutput("t4_pending", 32'(pending), 32'd0);
    applyStimulus(1'b1, 16'h0010, '1, 1'b0, 1'b0); step(); step();
    checkOutput("t4_req", 32'(irq_req), 32'd0);
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b0); step();

    // Take and return together; re-rise on the served bit during take
    applyStimulus(1'b1, 16'h0040, '1, 1'b0, 1'b0); step(); step();
    applyStimulus(1'b1, '0, '1, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 16'h0040, '1, 1'b1, 1'b1); step();
    checkOutput("t5_busy", 32'(busy), 32'd1);
    checkOutput("t5_pend6", 32'(pending[6]), 32'd1);
    applyStimulus(1'b1, 16'h0040, '1, 1'b0, 1'b1); step();
    applyStimulus(1'b1, 16'h0040, '1, 1'b0, 1'b0); step();
    checkOutput("t5_rereq", 32'(irq_id), 32'd6);

    // Reset during service, line 0 held high through release
    applyStimulus(1'b1, 16'h0041, '1, 1'b1, 1'b0); step();
    applyStimulus(1'b0, 16'h0001, '1, 1'b0, 1'b0); step();
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_pending", 32'(pending), 32'd0);
    checkOutput("t6_rst_cause", irq_cause, 32'd0);
    applyStimulus(1'b1, 16'h0001, '1, 1'b0, 1'b0); step();
    checkOutput("t6_req_early", 32'(irq_req), 32'd0);
    step();
    checkOutput("t6_req", 32'(irq_req), 32'd1);
    checkOutput("t6_id", 32'(irq_id), 32'd0);

    // Randomized traffic against the model
    s = src;
    for (int n = 0; n < 3000; n++) begin
      s = s ^ NUM_SRC'($urandom & $urandom & $urandom);
      applyStimulus($urandom_range(0, 199) != 0, s,
                    ~NUM_SRC'($urandom & $urandom & $urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
